// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU micro-sequencer: opcodes, instruction fields, FSM encoding.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_NOT = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;
    localparam logic [2:0] OP_SLA = 3'b101;
    localparam logic [2:0] OP_BEQ = 3'b110;
    localparam logic [2:0] OP_BNE = 3'b111;

    localparam int SEL_LO   = 13;
    localparam int RD_LO    = 11;
    localparam int RS1_LO   = 9;
    localparam int RS2_LO   = 7;
    localparam int IMM_LO   = 0;
    localparam int HALT_BIT = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Both branch opcodes have the two top sel bits set.
    function automatic logic is_branch(input logic [2:0] sel);
        return sel[2] & sel[1];
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// 4 x 8-bit register file: one write port, three combinational read ports.
// Writes land on the clock edge, so a same-cycle read returns the old value.
module alu_seq_regfile (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we_i,
    input  logic [1:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [1:0] raddr_a_i,
    input  logic [1:0] raddr_b_i,
    input  logic [1:0] raddr_c_i,
    output logic [7:0] rdata_a_o,
    output logic [7:0] rdata_b_o,
    output logic [7:0] rdata_c_o
);

    logic [7:0] regs_q [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];
    assign rdata_c_o = regs_q[raddr_c_i];

endmodule

// File: rtl/alu_sequencer.sv
// Micro-sequencer driving an external 8-bit ALU from sync instruction memory; 2 cycles/instr.
// start/cfg_we are ignored while busy; a program without HALT runs until rst_n.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int PC_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            ovf_sticky,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    output logic [2:0]      alu_sel,
    input  logic [7:0]      alu_f,
    input  logic            alu_ovf,
    input  logic            alu_take_branch,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_addr,
    input  logic [7:0]      cfg_wdata,
    output logic [7:0]      cfg_rdata
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      a_hold_q, b_hold_q;

    logic [2:0]  dec_sel;
    logic [1:0]  dec_rd, dec_rs1, dec_rs2;
    logic [6:0]  dec_imm;
    logic [15:0] br_off;
    logic        in_exec, in_rest, dec_br, dec_halt;

    logic       rf_we;
    logic [1:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic [7:0] rs1_val, rs2_val;

    assign dec_sel  = imem_data[SEL_LO +: 3];
    assign dec_rd   = imem_data[RD_LO  +: 2];
    assign dec_rs1  = imem_data[RS1_LO +: 2];
    assign dec_rs2  = imem_data[RS2_LO +: 2];
    assign dec_imm  = imem_data[IMM_LO +: 7];
    assign dec_br   = is_branch(dec_sel);
    assign dec_halt = !dec_br && imem_data[HALT_BIT];
    assign br_off   = {{9{dec_imm[6]}}, dec_imm};

    assign in_exec = (state_q == ST_EXEC);
    assign in_rest = (state_q == ST_IDLE) || (state_q == ST_DONE);

    alu_seq_regfile u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata),
        .raddr_a_i (dec_rs1),
        .raddr_b_i (dec_rs2),
        .raddr_c_i (cfg_addr),
        .rdata_a_o (rs1_val),
        .rdata_b_o (rs2_val),
        .rdata_c_o (cfg_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            ovf_q    <= 1'b0;
            a_hold_q <= '0;
            b_hold_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ovf_q   <= ovf_d;
            if (in_exec) begin
                a_hold_q <= rs1_val;
                b_hold_q <= rs2_val;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE,
            ST_DONE:  if (start) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC:  state_d = dec_halt ? ST_DONE : ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Host preload owns the write port outside FETCH/EXEC; the ALU writeback owns it in EXEC.
    always_comb begin
        pc_d     = pc_q;
        ovf_d    = ovf_q;
        rf_we    = 1'b0;
        rf_waddr = cfg_addr;
        rf_wdata = cfg_wdata;
        if (in_rest) begin
            rf_we = cfg_we;
            if (start) begin
                pc_d  = '0;
                ovf_d = 1'b0;
            end
        end else if (in_exec) begin
            if (dec_br) begin
                pc_d = alu_take_branch ? pc_q + br_off[PC_W-1:0] : pc_q + 1'b1;
            end else begin
                rf_we    = 1'b1;
                rf_waddr = dec_rd;
                rf_wdata = alu_f;
                if (dec_sel == OP_ADD) ovf_d = ovf_q | alu_ovf;
                if (!dec_halt) pc_d = pc_q + 1'b1;
            end
        end
    end

    always_comb begin
        busy       = (state_q == ST_FETCH) || in_exec;
        done       = (state_q == ST_DONE);
        ovf_sticky = ovf_q;
        imem_addr  = pc_q;
        alu_sel    = in_exec ? dec_sel : OP_ADD;
        alu_a      = in_exec ? rs1_val : a_hold_q;
        alu_b      = in_exec ? rs2_val : b_hold_q;
    end

endmodule
